ticket_vend_param: RTL and testbench

TICKET_VEND_PARAM -- requirements
Module: ticket_vend_param

---
 rtl/ticket_vend_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ticket_vend_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ticket_vend_param.sv
`default_nettype none
// ============================================================================
// Module   : ticket_vend_param
// Purpose  : Parameterised ticket vending controller. A ticket type is chosen
//            with sel, coins are collected until the type's price is covered,
//            a one-cycle vend pulse is issued and any surplus credit is paid
//            back one coin per cycle using the largest coin that fits.
//            cancel (or the optional idle timeout) refunds the collected credit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_TKT       number of ticket types (1..8)
//   CW          credit register width, must hold max(price)+4
//   PRICES      packed prices, type i at [i*CW +: CW], each nonzero
//   TIMEOUT_CYC idle-coin timeout length in cycles (>=2)
// Ports
//   clk         clock, all state updates on rising edge
//   rst         synchronous active-high reset, highest priority
//   sel         ticket select request, one bit per type (lowest index wins)
//   coin_valid  coin strobe, one coin per cycle
//   x           coin code: 001=1, 010=2, 101=5, others illegal
//   cancel      abort purchase and refund credit
//   y           one-cycle vend pulse
//   tkt_id      index of the ticket being sold, valid while busy
//   re          change coin code (same encoding as x), valid with re_valid
//   re_valid    one change coin emitted this cycle
//   credit      current credit
//   busy        high in every state except IDLE
//   timeout     one-cycle pulse when the idle timeout aborts a purchase
// Build option
//   TICKET_TIMEOUT_EN  when defined, a purchase that sees no legal coin for
//                      TIMEOUT_CYC consecutive COLLECT cycles is aborted as if
//                      cancelled; when undefined COLLECT waits indefinitely
//                      and timeout is tied low.
// ============================================================================
module ticket_vend_param #(
  parameter int                  N_TKT       = 3,
  parameter int                  CW          = 5,
  parameter logic [N_TKT*CW-1:0] PRICES      = {5'd15, 5'd10, 5'd5},
  parameter int                  TIMEOUT_CYC = 16,
  localparam int                 TW          = (N_TKT > 1) ? $clog2(N_TKT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_TKT-1:0] sel,
  input  logic             coin_valid,
  input  logic [2:0]       x,
  input  logic             cancel,
  output logic             y,
  output logic [TW-1:0]    tkt_id,
  output logic [2:0]       re,
  output logic             re_valid,
  output logic [CW-1:0]    credit,
  output logic             busy,
  output logic             timeout
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity check
  // --------------------------------------------------------------------------
  generate
    if ((N_TKT < 1) || (N_TKT > 8) || (CW < 3) || (TIMEOUT_CYC < 2)) begin : g_bad_param
      $error("ticket_vend_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_credit, w_credit_nxt;
  logic [TW-1:0]   r_tkt_id, w_tkt_id_nxt;
  logic            r_y, w_y_nxt;
  logic [2:0]      r_re, w_re_nxt;
  logic            r_re_valid, w_re_valid_nxt;

  logic [TW-1:0]   w_sel_idx;
  logic [CW-1:0]   w_price;
  logic            w_coin_legal;
  logic            w_coin_ok;
  logic [CW-1:0]   w_coin_val;
  logic [CW-1:0]   w_sum;
  logic [2:0]      w_chg_code;
  logic [CW-1:0]   w_chg_val;
  logic            w_tmo_hit;

  // --------------------------------------------------------------------------
  // Lowest set select bit wins; scan high to low so the last hit is lowest.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_idx = '0;
    for (int i = N_TKT - 1; i >= 0; i--) begin
      if (sel[i]) begin
        w_sel_idx = TW'(i);
      end
    end
  end

  // Price lookup by mux so an unused tkt_id encoding never indexes past PRICES.
  always_comb begin
    w_price = PRICES[CW-1:0];
    for (int i = 0; i < N_TKT; i++) begin
      if (r_tkt_id == TW'(i)) begin
        w_price = PRICES[i*CW +: CW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Coin decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_coin_legal = 1'b1;
    w_coin_val   = '0;
    case (x)
      3'b001:  w_coin_val = CW'(1);
      3'b010:  w_coin_val = CW'(2);
      3'b101:  w_coin_val = CW'(5);
      default: w_coin_legal = 1'b0;
    endcase
  end

  assign w_coin_ok = coin_valid & w_coin_legal;
  // Credit never exceeds price-1 before a coin, so price+4 always fits in CW.
  assign w_sum     = r_credit + w_coin_val;

  // Largest change coin not exceeding the remaining credit.
  always_comb begin
    if (r_credit >= CW'(5)) begin
      w_chg_code = 3'b101;
      w_chg_val  = CW'(5);
    end else if (r_credit >= CW'(2)) begin
      w_chg_code = 3'b010;
      w_chg_val  = CW'(2);
    end else begin
      w_chg_code = 3'b001;
      w_chg_val  = CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Optional idle-coin timeout
  // --------------------------------------------------------------------------
`ifdef TICKET_TIMEOUT_EN
  localparam int TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TCW-1:0] r_tcnt;
  logic           r_timeout;

  // r_tcnt counts completed coin-less COLLECT cycles; the cycle in which it
  // already holds TIMEOUT_CYC-1 is the TIMEOUT_CYC-th one and aborts.
  assign w_tmo_hit = (r_tcnt == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == ST_COLLECT) && !cancel && !w_coin_ok && w_tmo_hit;
      // Held at zero outside COLLECT, so entry into COLLECT starts from zero.
      if ((r_state != ST_COLLECT) || w_coin_ok) begin
        r_tcnt <= '0;
      end else if (!w_tmo_hit) begin
        r_tcnt <= r_tcnt + TCW'(1);
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_tkt_id   <= '0;
      r_y        <= 1'b0;
      r_re       <= 3'b000;
      r_re_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_tkt_id   <= w_tkt_id_nxt;
      r_y        <= w_y_nxt;
      r_re       <= w_re_nxt;
      r_re_valid <= w_re_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next output values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_tkt_id_nxt   = r_tkt_id;
    w_y_nxt        = 1'b0;
    w_re_nxt       = 3'b000;
    w_re_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (sel != '0) begin
          w_tkt_id_nxt = w_sel_idx;
          w_credit_nxt = '0;
          w_state_nxt  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          // A coin arriving with cancel is banked first, then refunded in full.
          w_credit_nxt = w_coin_ok ? w_sum : r_credit;
          w_state_nxt  = (w_credit_nxt != '0) ? ST_CHANGE : ST_IDLE;
        end else if (w_coin_ok) begin
          if (w_sum >= w_price) begin
            w_credit_nxt = w_sum - w_price;
            w_state_nxt  = ST_VEND;
          end else begin
            w_credit_nxt = w_sum;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end
      end

      ST_VEND: begin
        w_y_nxt     = 1'b1;
        w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        w_re_nxt       = w_chg_code;
        w_re_valid_nxt = 1'b1;
        w_credit_nxt   = r_credit - w_chg_val;
        if (r_credit == w_chg_val) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  assign y        = r_y;
  assign tkt_id   = r_tkt_id;
  assign re       = r_re;
  assign re_valid = r_re_valid;
  assign credit   = r_credit;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ticket_vend_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ticket_vend_param
// Purpose  : Directed self-checking bench for ticket_vend_param with default
//            parameters. Inputs are driven 1 ns after each rising edge and
//            outputs are checked at the same point, i.e. they reflect the edge
//            just taken. Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ticket_vend_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic       coin_valid;
  logic [2:0] x;
  logic       cancel;
  logic       y;
  logic [1:0] tkt_id;
  logic [2:0] re;
  logic       re_valid;
  logic [4:0] credit;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  ticket_vend_param dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .coin_valid (coin_valid),
    .x          (x),
    .cancel     (cancel),
    .y          (y),
    .tkt_id     (tkt_id),
    .re         (re),
    .re_valid   (re_valid),
    .credit     (credit),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    sel = 3'b000; coin_valid = 1'b0; x = 3'b000; cancel = 1'b0;
  endtask

  task automatic coin(input logic [2:0] code);
    coin_valid = 1'b1; x = code;
    step();
    coin_valid = 1'b0; x = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    sel = 3'b001;  // rst must dominate a simultaneous select
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_credit", credit, 0);
    chk("rst_tkt", tkt_id, 0);
    chk("rst_y", y, 0);
    chk("rst_re", re, 0);
    chk("rst_rv", re_valid, 0);
    chk("rst_tmo", timeout, 0);
    rst = 1'b0;

    // ---- price 5: coins 2,2,1, exact payment ----
    sel = 3'b001; step(); sel = 3'b000;
    chk("t1_busy", busy, 1);
    chk("t1_tkt", tkt_id, 0);
    coin(3'b010); chk("t1_cr2", credit, 2);
    coin(3'b010); chk("t1_cr4", credit, 4);
    coin(3'b001); chk("t1_cr_done", credit, 0);
    chk("t1_y_early", y, 0);
    step();
    chk("t1_y", y, 1);
    chk("t1_rv", re_valid, 0);
    chk("t1_idle", busy, 0);
    step();
    chk("t1_y_off", y, 0);
    chk("t1_rv_off", re_valid, 0);

    // ---- price 10: coins 5,2,5 -> change 2 ----
    sel = 3'b010; step(); sel = 3'b000;
    chk("t2_tkt", tkt_id, 1);
    coin(3'b101); chk("t2_cr5", credit, 5);
    coin(3'b010); chk("t2_cr7", credit, 7);
    coin(3'b101); chk("t2_cr2", credit, 2);
    step();
    chk("t2_y", y, 1);
    chk("t2_rv0", re_valid, 0);
    chk("t2_busy", busy, 1);
    step();
    chk("t2_y_off", y, 0);
    chk("t2_rv", re_valid, 1);
    chk("t2_re", re, 3'b010);
    chk("t2_cr0", credit, 0);
    chk("t2_idle", busy, 0);
    step();
    chk("t2_rv_once", re_valid, 0);

    // ---- price 15: coins 5,2 then cancel -> refund 5,2 ----
    sel = 3'b100; step(); sel = 3'b000;
    chk("t3_tkt", tkt_id, 2);
    coin(3'b101);
    coin(3'b010); chk("t3_cr7", credit, 7);
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("t3_y_c", y, 0);
    chk("t3_cr_c", credit, 7);
    step();
    chk("t3_re1", re, 3'b101);
    chk("t3_rv1", re_valid, 1);
    chk("t3_cr1", credit, 2);
    chk("t3_y1", y, 0);
    step();
    chk("t3_re2", re, 3'b010);
    chk("t3_rv2", re_valid, 1);
    chk("t3_cr2", credit, 0);
    chk("t3_idle", busy, 0);
    step();
    chk("t3_rv_off", re_valid, 0);
    chk("t3_y_off", y, 0);

    // ---- sel=111 priority, illegal codes, cancel with completing coin ----
    sel = 3'b111; step(); sel = 3'b000;
    chk("t4_tkt", tkt_id, 0);
    coin(3'b011); chk("t4_ill3", credit, 0);
    coin(3'b110); chk("t4_ill6", credit, 0);
    x = 3'b101; step(); x = 3'b000;   // code present without strobe
    chk("t4_nostrobe", credit, 0);
    coin(3'b010); chk("t4_cr2", credit, 2);
    cancel = 1'b1; coin(3'b101); cancel = 1'b0;
    chk("t4_cc_cr", credit, 7);
    chk("t4_cc_busy", busy, 1);
    step();
    chk("t4_cc_y", y, 0);
    chk("t4_cc_re1", re, 3'b101);
    step();
    chk("t4_cc_re2", re, 3'b010);
    chk("t4_cc_idle", busy, 0);
    // cancel with zero credit goes straight home without change
    sel = 3'b001; step(); sel = 3'b000;
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("t4_c0_idle", busy, 0);
    step();
    chk("t4_c0_rv", re_valid, 0);

    // ---- reset in CHANGE with credit 3 ----
    sel = 3'b010; step(); sel = 3'b000;
    coin(3'b010); coin(3'b010); coin(3'b010); coin(3'b010);
    coin(3'b101);                      // 13 - 10 = 3
    chk("t5_cr3", credit, 3);
    step();                            // VEND -> CHANGE
    chk("t5_y", y, 1);
    chk("t5_cr3b", credit, 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_cr0", credit, 0);
    chk("t5_rv", re_valid, 0);
    chk("t5_y_off", y, 0);
    step();
    chk("t5_rv_after", re_valid, 0);

    // ---- idle-coin timeout ----
    sel = 3'b001; step(); sel = 3'b000;
    coin(3'b001); chk("t6_cr1", credit, 1);
    for (int i = 0; i < 15; i++) step();
    chk("t6_tmo_early", timeout, 0);
    chk("t6_busy15", busy, 1);
    step();
`ifdef TICKET_TIMEOUT_EN
    chk("t6_tmo", timeout, 1);
    step();
    chk("t6_tmo_off", timeout, 0);
    chk("t6_re", re, 3'b001);
    chk("t6_rv", re_valid, 1);
    chk("t6_cr0", credit, 0);
    chk("t6_idle", busy, 0);
`else
    chk("t6_tmo", timeout, 0);
    chk("t6_wait_busy", busy, 1);
    chk("t6_wait_cr", credit, 1);
    for (int i = 0; i < 8; i++) step();
    chk("t6_still_busy", busy, 1);
    cancel = 1'b1; step(); cancel = 1'b0;
    step();
    chk("t6_re", re, 3'b001);
    chk("t6_idle", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
